sysbus_xor_port: RTL and testbench
==================================

Name: sysbus_xor_port

Overview:
- Memory-mapped bus responder on the processor's shared `sysbus`; it is the target side of the CPU's MAR/CS/R_NW memory cycles.
- Buffers incoming ciphertext bytes from an external stream in an RX FIFO for the CPU to read.
- Accepts CPU writes into a TX FIFO, XOR-ing each byte with a programmable key, and streams them out with a valid/ready handshake.
- Sits alongside ram/rom on `sysbus`, in an address window that does not overlap them.

Parameters:
- WORD_W, 8, sysbus/data width.
- OP_W, 3, opcode width; address width ADDR_W = WORD_W-OP_W.
- BASE_ADDR, 5'b11100, base of the 4-word register window; bits [1:0] must be 0.
- FIFO_DEPTH, 4, entries per FIFO, power of 2, ≥2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- sysbus  inout  WORD_W  shared address/data bus; driven only during selected reads, else high-Z.
- load_MAR  input  1  address phase: sysbus carries the address this cycle.
- CS  input  1  bus access strobe.
- R_NW  input  1  1 = read (port drives sysbus), 0 = write.
- rx_data  input  WORD_W  inbound stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  RX FIFO can accept; equals !rx_full.
- tx_data  output  WORD_W  head of TX FIFO.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  downstream accepts tx_data.

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - Both FIFOs empty; rx_ready=1, tx_valid=0, tx_data=0.
  - key=0, sticky flags=0, addr=0, cs_q=0.
  - sysbus high-Z.
  - Reset mid-transfer discards all FIFO contents.
- Address capture: on a rising edge with load_MAR=1, addr <= sysbus[ADDR_W-1:0].
- Decode:
  - sel = (addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]); off = addr[1:0].
  - Not selected: port never drives sysbus and ignores CS.
- Access event:
  - cs_q is CS registered each cycle.
  - acc = CS & !cs_q & sel, i.e. exactly one action per CS assertion regardless of how long CS is held.
- Read data path:
  - sysbus is driven combinationally whenever CS & R_NW & sel, for every cycle CS is high.
  - Read data by offset:
    - 0 RXDATA: RX head, or 0 if RX is empty.
    - 1 TXDATA: reads 0.
    - 2 STATUS: {0..., tx_ovf, rx_unf, tx_full, rx_nempty} in bits [3:0], upper bits 0.
    - 3 KEY: key.
- Read side effects (on an edge with acc & R_NW):
  - off 0 pops RX if non-empty.
  - off 0 with RX empty sets rx_unf instead.
- Write side effects (on an edge with acc & !R_NW), data = sysbus:
  - off 1 pushes (data ^ key) into TX.
    - Accepted if TX is not full, or if a TX drain (tx_valid & tx_ready) occurs on the same edge.
    - Otherwise the byte is dropped and tx_ovf is set.
  - off 2: any write clears rx_unf and tx_ovf. If a new error occurs on the same edge, the set wins.
  - off 3: key <= data. A TXDATA push that uses the key takes the old key; writes are one per access, so there is no conflict.
  - off 0: ignored.
- RX stream:
  - Push on an edge with rx_valid & rx_ready.
  - rx_ready depends only on the registered count, so a full FIFO with a simultaneous CPU pop still refuses the push.
  - A simultaneous push and pop with the FIFO non-full leaves the count unchanged and preserves order.
- TX stream:
  - tx_data/tx_valid come from the FIFO head.
  - Pop on an edge with tx_valid & tx_ready.
  - tx_data must remain stable while tx_valid & !tx_ready.
- FIFOs:
  - Circular buffers with read/write pointers and a count of width log2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Strict FIFO order.
- Latency:
  - RX byte readable by the CPU on the cycle after its push edge.
  - TX byte visible on tx_data one cycle after the write edge.

Test Plan:
- Reset: assert reset for 2 cycles with rx_valid=1 → rx_ready=1, tx_valid=0, sysbus Z, STATUS read = 8'h00, KEY read = 8'h00.
- RX path: stream 8'hA1, 8'hB2, 8'hC3 → STATUS bit0=1. Three RXDATA reads (addr 5'b11100) return A1, B2, C3. A fourth read returns 8'h00 and sets STATUS = 8'h04. Write STATUS → 8'h00.
- XOR TX: write KEY (5'b11111) = 8'h5A, write TXDATA (5'b11101) = 8'h3C with tx_ready=0 → tx_valid=1, tx_data=8'h66 stable for 5 cycles. Raise tx_ready → popped, tx_valid=0.
- TX full/overflow: tx_ready=0, five TXDATA writes of 01..05 with key 0 → STATUS = 8'h0A. Drain outputs 01, 02, 03, 04 only.
- Full boundary: fill RX to 4 entries with rx_valid held → rx_ready=0. One CPU pop on the same cycle → push refused that edge, accepted the next edge, order preserved.
- Held CS / unselected: hold a CS read of RXDATA for 3 cycles → exactly one pop. Access at address 5'b00010 → sysbus never driven by the port, no state change.

Source files
------------

// File: rtl/sysbus_xor_port_if.sv
`timescale 1ns/1ps
// Bus control strobes plus the RX/TX byte streams of sysbus_xor_port.
// The shared tri-state sysbus itself stays a plain inout port on the module.
interface sysbus_xor_port_if #(
    parameter int WORD_W = 8
);
    logic              load_MAR;
    logic              CS;
    logic              R_NW;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [WORD_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output load_MAR, CS, R_NW, rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  load_MAR, CS, R_NW, rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/sysbus_xor_port.sv
`timescale 1ns/1ps
// Memory-mapped sysbus target: an RX byte FIFO the CPU drains by reading, and a
// TX FIFO filled by CPU writes XOR-ed with a key and streamed out over valid/ready.
module sysbus_xor_port #(
    parameter int                      WORD_W     = 8,
    parameter int                      OP_W       = 3,
    parameter logic [WORD_W-OP_W-1:0]  BASE_ADDR  = 5'b11100,
    parameter int                      FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    inout  wire  [WORD_W-1:0] sysbus,
    sysbus_xor_port_if.slave  port_if
);
    localparam int ADDR_W = WORD_W - OP_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        OFF_RXDATA = 2'd0,
        OFF_TXDATA = 2'd1,
        OFF_STATUS = 2'd2,
        OFF_KEY    = 2'd3
    } reg_off_e;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic [WORD_W-1:0] key_q, key_d;
    logic              rx_unf_q, rx_unf_d;
    logic              tx_ovf_q, tx_ovf_d;

    logic [WORD_W-1:0] rx_mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] rx_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;

    logic [WORD_W-1:0] tx_mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] tx_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;

    logic              sel;
    reg_off_e          off;
    logic              acc, acc_rd, acc_wr;
    logic              bus_oe;
    logic [WORD_W-1:0] rd_data;

    logic rx_empty, rx_full, rx_push, rx_pop, rx_unf_set;
    logic tx_empty, tx_full, tx_pop, tx_wr, tx_push, tx_ovf_set, stat_clr;

    // Decode uses the latched address; one access event per rising CS.
    always_comb begin
        sel    = (addr_q[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
        off    = reg_off_e'(addr_q[1:0]);
        acc    = port_if.CS & ~cs_q & sel;
        acc_rd = acc & port_if.R_NW;
        acc_wr = acc & ~port_if.R_NW;
        bus_oe = port_if.CS & port_if.R_NW & sel;
    end

    always_comb begin
        rx_empty   = (rx_cnt_q == '0);
        rx_full    = (rx_cnt_q == FULL_CNT);
        rx_push    = port_if.rx_valid & ~rx_full;
        rx_pop     = acc_rd & (off == OFF_RXDATA) & ~rx_empty;
        rx_unf_set = acc_rd & (off == OFF_RXDATA) & rx_empty;

        tx_empty   = (tx_cnt_q == '0);
        tx_full    = (tx_cnt_q == FULL_CNT);
        tx_pop     = ~tx_empty & port_if.tx_ready;
        tx_wr      = acc_wr & (off == OFF_TXDATA);
        // A drain on the same edge frees the slot a full FIFO needs.
        tx_push    = tx_wr & (~tx_full | tx_pop);
        tx_ovf_set = tx_wr & ~tx_push;
        stat_clr   = acc_wr & (off == OFF_STATUS);
    end

    assign port_if.rx_ready = ~rx_full;
    assign port_if.tx_valid = ~tx_empty;
    assign port_if.tx_data  = tx_empty ? '0 : tx_mem_q[tx_rd_q];

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_RXDATA: rd_data = rx_empty ? '0 : rx_mem_q[rx_rd_q];
            OFF_TXDATA: rd_data = '0;
            OFF_STATUS: rd_data = {{(WORD_W-4){1'b0}}, tx_ovf_q, rx_unf_q, tx_full, ~rx_empty};
            OFF_KEY:    rd_data = key_q;
            default:    rd_data = '0;
        endcase
    end

    assign sysbus = bus_oe ? rd_data : {WORD_W{1'bz}};

    always_comb begin
        addr_d   = port_if.load_MAR ? sysbus[ADDR_W-1:0] : addr_q;
        cs_d     = port_if.CS;
        key_d    = (acc_wr && off == OFF_KEY) ? sysbus : key_q;
        // Set beats clear when an error lands on the same edge as a STATUS write.
        rx_unf_d = rx_unf_set | (rx_unf_q & ~stat_clr);
        tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~stat_clr);
    end

    always_comb begin
        rx_mem_d = rx_mem_q;
        rx_rd_d  = rx_rd_q;
        rx_wr_d  = rx_wr_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = port_if.rx_data;
            rx_wr_d           = rx_wr_q + PTR_W'(1);
        end
        if (rx_pop) begin
            rx_rd_d = rx_rd_q + PTR_W'(1);
        end
        rx_cnt_d = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
    end

    // The pushed byte is XOR-ed with the key held before this edge.
    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_rd_d  = tx_rd_q;
        tx_wr_d  = tx_wr_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = sysbus ^ key_q;
            tx_wr_d           = tx_wr_q + PTR_W'(1);
        end
        if (tx_pop) begin
            tx_rd_d = tx_rd_q + PTR_W'(1);
        end
        tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q   <= '0;
            cs_q     <= 1'b0;
            key_q    <= '0;
            rx_unf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            rx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_cnt_q <= '0;
            tx_rd_q  <= '0;
            tx_wr_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            key_q    <= key_d;
            rx_unf_q <= rx_unf_d;
            tx_ovf_q <= tx_ovf_d;
            rx_rd_q  <= rx_rd_d;
            rx_wr_q  <= rx_wr_d;
            rx_cnt_q <= rx_cnt_d;
            tx_rd_q  <= tx_rd_d;
            tx_wr_q  <= tx_wr_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // Storage needs no reset: occupancy counts decide what is valid.
    always_ff @(posedge clock) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end
endmodule

// File: tb/tb_sysbus_xor_port.sv
`timescale 1ns/1ps
// Scoreboard bench for sysbus_xor_port: CPU bus tasks, a stream monitor and
// queues holding the bytes the CPU and the TX consumer are expected to see.
module tb_sysbus_xor_port;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    wire  [7:0] sysbus;
    logic [7:0] bus_drv = '0;
    logic       bus_en  = 1'b0;

    assign sysbus = bus_en ? bus_drv : 8'bzzzz_zzzz;

    sysbus_xor_port_if #(.WORD_W(8)) port_if ();

    sysbus_xor_port #(
        .WORD_W(8), .OP_W(3), .BASE_ADDR(5'b11100), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .sysbus(sysbus), .port_if(port_if)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    logic [7:0] m_key    = '0;
    logic       m_rx_unf = 1'b0;
    logic       m_tx_ovf = 1'b0;

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_status();
        return {4'b0000, m_tx_ovf, m_rx_unf, tx_exp.size() == DEPTH, rx_exp.size() != 0};
    endfunction

    // Stream monitor, sampled just before each rising edge.
    logic [7:0] last_tx = '0;
    logic       hold_pending = 1'b0;
    initial forever begin
        @(negedge clock);
        #4;
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (port_if.rx_valid && port_if.rx_ready) rx_exp.push_back(port_if.rx_data);
            if (hold_pending) begin
                check_output("tx_valid_hold", port_if.tx_valid, 1'b1);
                check_output("tx_data_hold", port_if.tx_data, last_tx);
            end
            hold_pending = port_if.tx_valid && !port_if.tx_ready;
            last_tx      = port_if.tx_data;
            if (port_if.tx_valid && port_if.tx_ready) begin
                if (tx_exp.size() == 0) check_output("tx_unexpected", port_if.tx_valid, 1'b0);
                else check_output("tx_data", port_if.tx_data, tx_exp.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_addr(input logic [4:0] a);
        @(negedge clock);
        port_if.load_MAR = 1'b1;
        bus_en  = 1'b1;
        bus_drv = {3'b000, a};
        @(negedge clock);
        port_if.load_MAR = 1'b0;
        bus_en = 1'b0;
    endtask

    task automatic cpu_read(input logic [4:0] a, input string tag, input logic [7:0] exp, input logic exp_oe);
        set_addr(a);
        port_if.CS   = 1'b1;
        port_if.R_NW = 1'b1;
        #1;
        check_output({tag, "_oe"}, dut.bus_oe, exp_oe);
        if (exp_oe) check_output(tag, sysbus, exp);
        @(negedge clock);
        port_if.CS   = 1'b0;
        port_if.R_NW = 1'b0;
    endtask

    task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
        set_addr(a);
        port_if.CS   = 1'b1;
        port_if.R_NW = 1'b0;
        bus_en  = 1'b1;
        bus_drv = d;
        @(negedge clock);
        port_if.CS = 1'b0;
        bus_en     = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] off, input string tag);
        logic [7:0] e;
        e = '0;
        case (off)
            2'd0: if (rx_exp.size() != 0) e = rx_exp.pop_front(); else m_rx_unf = 1'b1;
            2'd2: e = model_status();
            2'd3: e = m_key;
            default: e = '0;
        endcase
        cpu_read({3'b111, off}, tag, e, 1'b1);
    endtask

    task automatic reg_write(input logic [1:0] off, input logic [7:0] d);
        case (off)
            2'd1: if (tx_exp.size() < DEPTH) tx_exp.push_back(d ^ m_key); else m_tx_ovf = 1'b1;
            2'd2: begin m_rx_unf = 1'b0; m_tx_ovf = 1'b0; end
            2'd3: m_key = d;
            default: ;
        endcase
        cpu_write({3'b111, off}, d);
    endtask

    task automatic wait_tx_drain(input string tag);
        int n;
        n = 0;
        while (tx_exp.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_output(tag, 8'(tx_exp.size()), 8'd0);
    endtask

    initial begin
        logic [7:0] rx_pat [3];
        logic [7:0] e;
        logic       exp_ready;
        rx_pat = '{8'hA1, 8'hB2, 8'hC3};

        port_if.load_MAR = 1'b0;
        port_if.CS       = 1'b0;
        port_if.R_NW     = 1'b0;
        port_if.rx_data  = 8'hEE;
        port_if.rx_valid = 1'b1;
        port_if.tx_ready = 1'b0;

        // Reset with rx_valid held high
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_output("reset_rx_ready", port_if.rx_ready, 1'b1);
        check_output("reset_tx_valid", port_if.tx_valid, 1'b0);
        check_output("reset_tx_data", port_if.tx_data, 8'h00);
        check_output("reset_bus_oe", dut.bus_oe, 1'b0);
        reset = 1'b0;
        port_if.rx_valid = 1'b0;
        reg_read(2'd2, "reset_status");
        reg_read(2'd3, "reset_key");

        // RX path and underflow
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            port_if.rx_valid = 1'b1;
            port_if.rx_data  = rx_pat[i];
        end
        @(negedge clock);
        port_if.rx_valid = 1'b0;
        reg_read(2'd2, "rx_status_nempty");
        for (int i = 0; i < 4; i++) reg_read(2'd0, "rx_read");
        reg_read(2'd2, "rx_status_unf");
        reg_write(2'd2, 8'h00);
        reg_read(2'd2, "rx_status_clear");

        // XOR TX with back-pressure
        reg_write(2'd3, 8'h5A);
        reg_read(2'd3, "key_read");
        reg_write(2'd1, 8'h3C);
        check_output("xor_tx_valid", port_if.tx_valid, 1'b1);
        check_output("xor_tx_data", port_if.tx_data, tx_exp[0]);
        repeat (5) begin
            @(negedge clock);
            check_output("xor_tx_stable", port_if.tx_data, tx_exp.size() != 0 ? tx_exp[0] : 8'h00);
        end
        port_if.tx_ready = 1'b1;
        wait_tx_drain("xor_drain");
        port_if.tx_ready = 1'b0;
        check_output("xor_tx_valid_after", port_if.tx_valid, 1'b0);
        reg_write(2'd3, 8'h00);

        // TX fill past capacity
        for (int i = 1; i <= 5; i++) reg_write(2'd1, 8'(i));
        reg_read(2'd2, "tx_ovf_status");
        port_if.tx_ready = 1'b1;
        wait_tx_drain("ovf_drain");
        port_if.tx_ready = 1'b0;
        check_output("ovf_tx_valid_after", port_if.tx_valid, 1'b0);
        reg_write(2'd2, 8'h00);
        reg_read(2'd2, "ovf_status_clear");

        // RX full with a CPU pop on the same edge
        @(negedge clock);
        port_if.rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            port_if.rx_data = 8'h10 + 8'(i);
            @(negedge clock);
        end
        port_if.rx_data = 8'h14;
        check_output("rx_ready_full", port_if.rx_ready, rx_exp.size() < DEPTH);
        set_addr(5'b11100);
        exp_ready = rx_exp.size() < DEPTH;
        e = rx_exp.pop_front();
        port_if.CS   = 1'b1;
        port_if.R_NW = 1'b1;
        #1;
        check_output("full_pop_data", sysbus, e);
        #3;
        check_output("rx_ready_full_pop", port_if.rx_ready, exp_ready);
        @(negedge clock);
        port_if.CS   = 1'b0;
        port_if.R_NW = 1'b0;
        @(negedge clock);
        port_if.rx_valid = 1'b0;
        check_output("rx_retry_count", 8'(rx_exp.size()), 8'(DEPTH));
        for (int i = 0; i < 4; i++) reg_read(2'd0, "full_order");
        reg_read(2'd2, "full_status_empty");

        // Held CS: one pop only
        @(negedge clock);
        port_if.rx_valid = 1'b1;
        port_if.rx_data  = 8'h77;
        @(negedge clock);
        port_if.rx_data  = 8'h88;
        @(negedge clock);
        port_if.rx_valid = 1'b0;
        set_addr(5'b11100);
        e = rx_exp.pop_front();
        port_if.CS   = 1'b1;
        port_if.R_NW = 1'b1;
        #1;
        check_output("held_cs_data", sysbus, e);
        repeat (3) @(negedge clock);
        port_if.CS   = 1'b0;
        port_if.R_NW = 1'b0;
        reg_read(2'd2, "held_cs_status");
        reg_read(2'd0, "held_cs_next");
        reg_read(2'd2, "held_cs_empty");

        // Unselected address
        @(negedge clock);
        port_if.rx_valid = 1'b1;
        port_if.rx_data  = 8'h99;
        @(negedge clock);
        port_if.rx_valid = 1'b0;
        set_addr(5'b00010);
        port_if.CS   = 1'b1;
        port_if.R_NW = 1'b1;
        repeat (3) begin
            #1;
            check_output("unsel_bus_oe", dut.bus_oe, 1'b0);
            @(negedge clock);
        end
        port_if.CS   = 1'b0;
        port_if.R_NW = 1'b0;
        cpu_write(5'b00011, 8'hFF);
        reg_read(2'd3, "unsel_key");
        reg_read(2'd2, "unsel_status");
        reg_read(2'd0, "unsel_rx");

        // Reset with both FIFOs occupied
        @(negedge clock);
        port_if.rx_valid = 1'b1;
        port_if.rx_data  = 8'h55;
        @(negedge clock);
        port_if.rx_data  = 8'h66;
        @(negedge clock);
        port_if.rx_valid = 1'b0;
        reg_write(2'd3, 8'h33);
        reg_write(2'd1, 8'hAA);
        check_output("pre_reset_tx_data", port_if.tx_data, tx_exp[0]);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rx_exp.delete();
        tx_exp.delete();
        m_key    = 8'h00;
        m_rx_unf = 1'b0;
        m_tx_ovf = 1'b0;
        check_output("midreset_tx_valid", port_if.tx_valid, 1'b0);
        check_output("midreset_rx_ready", port_if.rx_ready, 1'b1);
        reg_read(2'd2, "midreset_status");
        reg_read(2'd3, "midreset_key");
        reg_read(2'd0, "midreset_rx_empty");

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
